// File: rtl/ixc_osf_tbc_pkg.sv
// Shared types and constants for the osfTbc one-step-flow tick generator.
//   state_e      : step generator FSM states
//   TICK_TOTAL_W : width of the free-running issued-tick counter
//   cnt_width()  : bits needed to hold values 0..max_val (minimum 1)
package ixc_osf_tbc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StTick,
    StGap
  } state_e;

  localparam int unsigned TICK_TOTAL_W = 32;

  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ixc_osf_tbc_step_gen_if.sv
// Step request channel between the host and the osfTbc step generator.
//   req_valid : host has a request
//   req_ready : generator can accept (queue not full)
//   req_steps : number of ticks to issue for the request
// Modports: master = host side, slave = generator side.
interface ixc_osf_tbc_step_gen_if #(
  parameter int unsigned CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_steps;

  modport master (
    output req_valid,
    output req_steps,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_steps,
    output req_ready
  );
endinterface

// File: rtl/ixc_osf_tbc_req_fifo.sv
// Request queue for the osfTbc step generator: DEPTH x WIDTH synchronous FIFO with a
// registered occupancy count and a synchronous flush that wins over push and pop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : empty the queue next cycle; a push in the same cycle is dropped
//   push_i     : write data_i (ignored when full)
//   data_i     : entry to write
//   pop_i      : discard the head entry (ignored when empty)
//   data_o     : head entry
//   full_o     : queue full, from registered count
//   empty_o    : queue empty, from registered count
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module ixc_osf_tbc_req_fifo
  import ixc_osf_tbc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ixc_osf_tbc_step_gen.sv
// Driving end of the osfTbc one-step-flow tick line. Host step requests are queued and
// each is expanded into that many single-cycle, registered osfTbc ticks.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_if       : request channel (slave side): valid/ready/steps
//   hold_i       : consumer stall, no tick is issued in a cycle with hold high
//   abort_i      : flush queue and current run, priority over everything
//   osf_tbc_o    : registered tick, one cycle high per step
//   busy_o       : run in progress or requests queued
//   done_o       : one-cycle pulse when a request finishes
//   tick_total_o : free-running, wrapping count of issued ticks
module ixc_osf_tbc_step_gen
  import ixc_osf_tbc_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ixc_osf_tbc_step_gen_if.slave   req_if,
  input  logic                    hold_i,
  input  logic                    abort_i,
  output logic                    osf_tbc_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [TICK_TOTAL_W-1:0] tick_total_o
);

  localparam int unsigned GapW = cnt_width(GAP);
  // The gap counter counts down to zero, so it starts at GAP-1.
  localparam logic [GapW-1:0] GapInit = (GAP == 0) ? '0 : GapW'(GAP - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        remaining_q;
  logic [GapW-1:0]         gap_cnt_q;
  logic                    osf_tbc_q;
  logic                    done_q;
  logic [TICK_TOTAL_W-1:0] tick_total_q;

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_head;
  logic             req_push;
  logic             fifo_pop;
  logic             work_avail;

  assign req_if.req_ready = !fifo_full;
  assign req_push         = req_if.req_valid && !fifo_full;
  // LOAD always pops; the FIFO is guaranteed non-empty when LOAD is entered.
  assign fifo_pop         = (state_q == StLoad) && !abort_i;
  // Counting the push of this cycle lets a fresh request reach LOAD one cycle earlier
  // and keeps exactly one LOAD cycle between the runs of queued requests.
  assign work_avail       = !fifo_empty || req_push;

  ixc_osf_tbc_req_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (abort_i),
    .push_i  (req_push),
    .data_i  (req_if.req_steps),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      gap_cnt_q    <= '0;
      osf_tbc_q    <= 1'b0;
      done_q       <= 1'b0;
      tick_total_q <= '0;
    end else begin
      osf_tbc_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort_i) begin
        // Run dropped silently: no done, tick_total keeps its value.
        state_q     <= StIdle;
        remaining_q <= '0;
        gap_cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (work_avail) state_q <= StLoad;
          end
          StLoad: begin
            remaining_q <= fifo_head;
            if (fifo_head == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              state_q <= StTick;
            end
          end
          StTick: begin
            if (!hold_i) begin
              osf_tbc_q    <= 1'b1;
              remaining_q  <= remaining_q - CNT_W'(1);
              tick_total_q <= tick_total_q + TICK_TOTAL_W'(1);
              if (remaining_q == CNT_W'(1)) begin
                done_q  <= 1'b1;
                state_q <= work_avail ? StLoad : StIdle;
              end else if (GAP > 0) begin
                gap_cnt_q <= GapInit;
                state_q   <= StGap;
              end
            end
          end
          StGap: begin
            if (gap_cnt_q == '0) begin
              state_q <= StTick;
            end else begin
              gap_cnt_q <= gap_cnt_q - GapW'(1);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign osf_tbc_o    = osf_tbc_q;
  assign done_o       = done_q;
  assign tick_total_o = tick_total_q;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_ixc_osf_tbc_step_gen.sv
module tb_ixc_osf_tbc_step_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  ixc_osf_tbc_step_gen_if #(.CNT_W(16)) if0 ();
  ixc_osf_tbc_step_gen_if #(.CNT_W(16)) if2 ();

  logic        hold0, abort0, osf0, busy0, done0;
  logic [31:0] total0;
  logic        hold2, abort2, osf2, busy2, done2;
  logic [31:0] total2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_total0 = 32'd0;
  logic [31:0] exp_total2 = 32'd0;

  ixc_osf_tbc_step_gen #(.CNT_W(16), .DEPTH(4), .GAP(0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (if0),
    .hold_i       (hold0),
    .abort_i      (abort0),
    .osf_tbc_o    (osf0),
    .busy_o       (busy0),
    .done_o       (done0),
    .tick_total_o (total0)
  );

  ixc_osf_tbc_step_gen #(.CNT_W(16), .DEPTH(4), .GAP(2)) dut_gap (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (if2),
    .hold_i       (hold2),
    .abort_i      (abort2),
    .osf_tbc_o    (osf2),
    .busy_o       (busy2),
    .done_o       (done2),
    .tick_total_o (total2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.req_valid = 1'b0; if0.req_steps = '0; hold0 = 1'b0; abort0 = 1'b0;
    if2.req_valid = 1'b0; if2.req_steps = '0; hold2 = 1'b0; abort2 = 1'b0;
    #3;
    checks++; if (osf0 !== 1'b0) begin errors++; $display("FAIL reset_osf got %b exp 0", osf0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
    checks++; if (total0 !== 32'd0) begin errors++; $display("FAIL reset_total got %0h exp 0", total0); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", if0.req_ready); end
    checks++; if (if2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_gap got %b exp 1", if2.req_ready); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy_gap got %b exp 0", busy2); end
  endtask

  // Request of 3 accepted at edge t: ticks after edges t+2..t+4, done with the third.
  task automatic test_single();
    logic [15:0] eo, ed;
    eo = 16'b0000_0000_0001_1100;
    ed = 16'b0000_0000_0001_0000;
    if0.req_valid = 1'b1; if0.req_steps = 16'd3;
    cyc();
    if0.req_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      checks++; if (osf0 !== eo[i]) begin errors++; $display("FAIL single_osf[t+%0d] got %b exp %b", i, osf0, eo[i]); end
      checks++; if (done0 !== ed[i]) begin errors++; $display("FAIL single_done[t+%0d] got %b exp %b", i, done0, ed[i]); end
    end
    exp_total0 += 32'd3;
    checks++; if (total0 !== exp_total0) begin errors++; $display("FAIL single_total got %0d exp %0d", total0, exp_total0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy0); end
  endtask

  // Request of 4, hold high for the 2nd and 3rd tick opportunities (edges t+3, t+4).
  task automatic test_hold();
    logic [15:0] eo, ed;
    eo = 16'b0000_0000_1110_0100;
    ed = 16'b0000_0000_1000_0000;
    if0.req_valid = 1'b1; if0.req_steps = 16'd4;
    cyc();
    if0.req_valid = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      checks++; if (osf0 !== eo[i]) begin errors++; $display("FAIL hold_osf[t+%0d] got %b exp %b", i, osf0, eo[i]); end
      checks++; if (done0 !== ed[i]) begin errors++; $display("FAIL hold_done[t+%0d] got %b exp %b", i, done0, ed[i]); end
      hold0 = (i == 2) || (i == 3);
    end
    exp_total0 += 32'd4;
    checks++; if (total0 !== exp_total0) begin errors++; $display("FAIL hold_total got %0d exp %0d", total0, exp_total0); end
  endtask

  // Requests 2, 0, 1 pushed on edges t, t+1, t+2.
  task automatic test_back_to_back();
    logic [15:0] eo, ed;
    logic [15:0] st [3];
    int          ndone;
    st[0] = 16'd2; st[1] = 16'd0; st[2] = 16'd1;
    eo = 16'b0000_0000_1000_1100;
    ed = 16'b0000_0000_1001_1000;
    ndone = 0;
    for (int i = 0; i <= 10; i++) begin
      if0.req_valid = (i <= 2);
      if0.req_steps = (i <= 2) ? st[i] : 16'd0;
      cyc();
      ndone += int'(done0);
      checks++; if (osf0 !== eo[i]) begin errors++; $display("FAIL b2b_osf[t+%0d] got %b exp %b", i, osf0, eo[i]); end
      checks++; if (done0 !== ed[i]) begin errors++; $display("FAIL b2b_done[t+%0d] got %b exp %b", i, done0, ed[i]); end
    end
    if0.req_valid = 1'b0;
    checks++; if (ndone != 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", ndone); end
    exp_total0 += 32'd3;
    checks++; if (total0 !== exp_total0) begin errors++; $display("FAIL b2b_total got %0d exp %0d", total0, exp_total0); end
  endtask

  // Hold high while pushing 1-step requests: the first is popped into the stalled run,
  // the next DEPTH fill the queue and ready drops; ready returns when LOAD pops.
  task automatic test_full();
    logic [15:0] er;
    int          ntick, ndone;
    bit          drained;
    er = 16'b0000_0000_0011_1110;
    hold0 = 1'b1;
    if0.req_valid = 1'b1; if0.req_steps = 16'd1;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (if0.req_ready !== er[k]) begin errors++; $display("FAIL full_ready[e%0d] got %b exp %b", k, if0.req_ready, er[k]); end
      cyc();
    end
    checks++; if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held got %b exp 0", if0.req_ready); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy0); end
    checks++; if (osf0 !== 1'b0) begin errors++; $display("FAIL full_osf_hold got %b exp 0", osf0); end
    hold0 = 1'b0;
    cyc();
    ntick = int'(osf0); ndone = int'(done0);
    checks++; if (osf0 !== 1'b1) begin errors++; $display("FAIL full_first_tick got %b exp 1", osf0); end
    checks++; if (if0.req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_pre_pop got %b exp 0", if0.req_ready); end
    cyc();
    ntick += int'(osf0); ndone += int'(done0);
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", if0.req_ready); end
    cyc();
    ntick += int'(osf0); ndone += int'(done0);
    if0.req_valid = 1'b0;
    drained = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      ntick += int'(osf0); ndone += int'(done0);
      if (!busy0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++; if (!drained) begin errors++; $display("FAIL full_drain_timeout got busy %b exp 0", busy0); end
    checks++; if (ntick != 6) begin errors++; $display("FAIL full_tick_count got %0d exp 6", ntick); end
    checks++; if (ndone != 6) begin errors++; $display("FAIL full_done_count got %0d exp 6", ndone); end
    exp_total0 += 32'd6;
    checks++; if (total0 !== exp_total0) begin errors++; $display("FAIL full_total got %0d exp %0d", total0, exp_total0); end
  endtask

  // Request 5 then two 1-step requests; abort lands on the edge after the 2nd tick,
  // together with a new request that must be dropped.
  task automatic test_abort();
    logic [15:0] eo, eb;
    eo = 16'b0000_0000_0000_1100;
    eb = 16'b0000_0000_0000_1111;
    for (int i = 0; i <= 7; i++) begin
      if0.req_valid = (i <= 2) || (i == 4);
      if0.req_steps = (i == 0) ? 16'd5 : ((i == 4) ? 16'd7 : 16'd1);
      abort0 = (i == 4);
      cyc();
      checks++; if (osf0 !== eo[i]) begin errors++; $display("FAIL abort_osf[t+%0d] got %b exp %b", i, osf0, eo[i]); end
      checks++; if (busy0 !== eb[i]) begin errors++; $display("FAIL abort_busy[t+%0d] got %b exp %b", i, busy0, eb[i]); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL abort_done[t+%0d] got %b exp 0", i, done0); end
    end
    if0.req_valid = 1'b0; abort0 = 1'b0;
    exp_total0 += 32'd2;
    checks++; if (total0 !== exp_total0) begin errors++; $display("FAIL abort_total got %0d exp %0d", total0, exp_total0); end
    checks++; if (if0.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", if0.req_ready); end
  endtask

  // GAP=2: ticks after edges t+2, t+5, t+8; counter preset to 0xFFFF_FFFE wraps to 1.
  task automatic test_gap_wrap();
    logic [15:0] eo, ed;
    eo = 16'b0000_0001_0010_0100;
    ed = 16'b0000_0001_0000_0000;
    force dut_gap.tick_total_q = 32'hFFFF_FFFE;
    cyc();
    release dut_gap.tick_total_q;
    exp_total2 = 32'hFFFF_FFFE;
    checks++; if (total2 !== exp_total2) begin errors++; $display("FAIL gap_preset got %0h exp %0h", total2, exp_total2); end
    for (int i = 0; i <= 10; i++) begin
      if2.req_valid = (i == 0);
      if2.req_steps = 16'd3;
      cyc();
      if (eo[i]) exp_total2 = exp_total2 + 32'd1;
      checks++; if (osf2 !== eo[i]) begin errors++; $display("FAIL gap_osf[t+%0d] got %b exp %b", i, osf2, eo[i]); end
      checks++; if (done2 !== ed[i]) begin errors++; $display("FAIL gap_done[t+%0d] got %b exp %b", i, done2, ed[i]); end
      checks++; if (total2 !== exp_total2) begin errors++; $display("FAIL gap_total[t+%0d] got %0h exp %0h", i, total2, exp_total2); end
    end
    if2.req_valid = 1'b0;
    checks++; if (total2 !== 32'd1) begin errors++; $display("FAIL gap_wrap_final got %0h exp 1", total2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL gap_busy_end got %b exp 0", busy2); end
  endtask

  // Asynchronous reset while a tick is on the line.
  task automatic test_async_reset();
    if0.req_valid = 1'b1; if0.req_steps = 16'd3;
    cyc();
    if0.req_valid = 1'b0;
    cyc();
    cyc();
    checks++; if (osf0 !== 1'b1) begin errors++; $display("FAIL areset_pre_tick got %b exp 1", osf0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (osf0 !== 1'b0) begin errors++; $display("FAIL areset_osf got %b exp 0", osf0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL areset_done got %b exp 0", done0); end
    checks++; if (total0 !== 32'd0) begin errors++; $display("FAIL areset_total got %0d exp 0", total0); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (osf0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
        errors++; $display("FAIL areset_after[%0d] got osf %b done %b busy %b exp 0 0 0", i, osf0, done0, busy0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_full();
    test_abort();
    test_gap_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
